// File: rtl/if_event_monitor.sv
// Response-side mismatch monitor: merges runs of identical dut/gold mismatch vectors
// into {vector, start timestamp, length} records buffered in a FWFT FIFO.
// Optional feature macro: IFMON_CMP_MASK_EN adds a cmp_mask port that hides bits from comparison.
module if_event_monitor #(
  parameter int NOUT  = 4,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NOUT-1:0] dut_out,
  input  logic [NOUT-1:0] gold_out,
`ifdef IFMON_CMP_MASK_EN
  input  logic [NOUT-1:0] cmp_mask,
`endif
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [NOUT-1:0] rd_vec,
  output logic [TS_W-1:0] rd_ts,
  output logic [7:0]      rd_len,
  output logic            overflow,
  input  logic            clr_ovf,
  output logic [15:0]     ev_count,
  output logic            busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = NOUT + TS_W + 8;

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [NOUT-1:0]   cur_vec_q, cur_vec_d;
  logic [TS_W-1:0]   cur_ts_q, cur_ts_d;
  logic [7:0]        cur_len_q, cur_len_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [REC_W-1:0]  mem_d [DEPTH];
  logic              overflow_q, overflow_d;
  logic [15:0]       ev_count_q, ev_count_d;

  logic [NOUT-1:0]   diff;
  logic              mismatch;
  logic              close_ev;
  logic              start_ev;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [REC_W-1:0]  head;

`ifdef IFMON_CMP_MASK_EN
  assign diff = (dut_out ^ gold_out) & ~cmp_mask;
`else
  assign diff = dut_out ^ gold_out;
`endif

  assign mismatch = en && (diff != '0);

  // Run tracking: a burst closes on any change, on disable, or when the length saturates;
  // a nonzero mismatch on the closing edge immediately opens the next burst.
  always_comb begin
    state_d   = state_q;
    cur_vec_d = cur_vec_q;
    cur_ts_d  = cur_ts_q;
    cur_len_d = cur_len_q;
    close_ev  = 1'b0;
    start_ev  = 1'b0;
    ts_d      = en ? ts_q + TS_ONE : ts_q;

    case (state_q)
      IDLE: begin
        if (mismatch) begin
          start_ev = 1'b1;
        end
      end
      BURST: begin
        if (en && (diff == cur_vec_q) && (cur_len_q != 8'hFF)) begin
          cur_len_d = cur_len_q + 8'd1;
        end else begin
          close_ev = 1'b1;
          if (mismatch) begin
            start_ev = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_ev) begin
      state_d   = BURST;
      cur_vec_d = diff;
      cur_ts_d  = ts_q;
      cur_len_d = 8'd1;
    end
  end

  // Wrap-bit pointers: equal pointers mean empty, same index with differing wrap bit means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_valid   = !fifo_empty;
  assign pop        = rd_valid && rd_ready;
  assign push       = close_ev && (!fifo_full || pop);
  assign drop       = close_ev && fifo_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {cur_vec_q, cur_ts_q, cur_len_q};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // A drop on the same edge as clr_ovf wins so no lost record goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    ev_count_d = ev_count_q;
    if (close_ev && (ev_count_q != 16'hFFFF)) begin
      ev_count_d = ev_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      cur_vec_q  <= '0;
      cur_ts_q   <= '0;
      cur_len_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      ev_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      cur_vec_q  <= cur_vec_d;
      cur_ts_q   <= cur_ts_d;
      cur_len_q  <= cur_len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      ev_count_q <= ev_count_d;
      mem_q      <= mem_d;
    end
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_vec   = rd_valid ? head[REC_W-1 -: NOUT] : '0;
  assign rd_ts    = rd_valid ? head[TS_W+7 -: TS_W] : '0;
  assign rd_len   = rd_valid ? head[7:0] : 8'd0;
  assign overflow = overflow_q;
  assign ev_count = ev_count_q;
  assign busy     = (state_q == BURST);

endmodule
